// File: rtl/cgra_cfg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cgra_cfg_pkg                                                 |
// | Description : Opcodes, command record and FSM states for the CGRA          |
// |               configuration sequencer.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cgra_cfg_pkg;

    typedef enum logic [1:0] {
        OP_WRITE   = 2'b00,
        OP_POLL    = 2'b01,
        OP_END     = 2'b10,
        OP_ILLEGAL = 2'b11
    } cfg_op_e;

    // One 66-bit table entry: op in the top two bits, then address, then data.
    typedef struct packed {
        cfg_op_e     op;
        logic [31:0] addr;
        logic [31:0] data;
    } cfg_cmd_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WR_REQ  = 3'd2,
        WR_RESP = 3'd3,
        RD_REQ  = 3'd4,
        RD_RESP = 3'd5,
        DONE    = 3'd6,
        ERR     = 3'd7
    } cfg_state_e;

    localparam logic [1:0] c_RESP_OKAY  = 2'b00;
    localparam logic [1:0] c_BURST_INCR = 2'b01;
    localparam logic [2:0] c_SIZE_4B    = 3'b010;

    // 32-bit word lives in the upper or lower half of the 64-bit data bus.
    function automatic logic [7:0] lane_strb(input logic addr_bit2);
        return addr_bit2 ? 8'hF0 : 8'h0F;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cgra_cfg_axi_bus.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : AXI_BUS                                                      |
// | Description : AXI4 bus bundle with master and slave views.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface AXI_BUS #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 64
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_lock;
    logic [3:0]                  aw_cache;
    logic [2:0]                  aw_prot;
    logic [3:0]                  aw_qos;
    logic [3:0]                  aw_region;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_lock;
    logic [3:0]                  ar_cache;
    logic [2:0]                  ar_prot;
    logic [3:0]                  ar_qos;
    logic [3:0]                  ar_region;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface
`default_nettype wire

// File: rtl/cgra_cfg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cgra_cfg_sequencer                                           |
// | Description : Walks a command table issuing single-beat AXI writes and     |
// |               polled reads until an END entry or an error.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module cgra_cfg_sequencer
    import cgra_cfg_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_USER_WIDTH = 64,
    parameter int IDX_WIDTH      = 4,
    parameter int POLL_TIMEOUT   = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic [IDX_WIDTH-1:0] cmd_idx_o,
    input  logic [65:0]          cmd_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    AXI_BUS.Master               axi_master_port
);

    localparam int                  c_POLL_W   = $clog2(POLL_TIMEOUT + 1);
    localparam logic [c_POLL_W-1:0] c_POLL_MAX = c_POLL_W'(POLL_TIMEOUT);

    cfg_cmd_t             w_cmd;
    cfg_state_e           r_state;
    logic [IDX_WIDTH-1:0] r_idx;
    logic [c_POLL_W-1:0]  r_poll;
    logic [31:0]          r_addr;
    logic [31:0]          r_data;
    logic                 r_aw_valid;
    logic                 r_w_valid;
    logic                 r_ar_valid;
    logic                 r_b_ready;
    logic                 r_r_ready;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;

    logic                 w_aw_pending;
    logic                 w_w_pending;
    logic                 w_last_idx;
    logic [31:0]          w_rd_word;
    logic [c_POLL_W-1:0]  w_poll_next;
    logic                 w_unused;

    assign w_cmd        = cmd_i;
    assign w_aw_pending = r_aw_valid & ~axi_master_port.aw_ready;
    assign w_w_pending  = r_w_valid & ~axi_master_port.w_ready;
    assign w_last_idx   = &r_idx;
    assign w_rd_word    = r_addr[2] ? axi_master_port.r_data[63:32]
                                    : axi_master_port.r_data[31:0];
    assign w_poll_next  = r_poll + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_poll     <= '0;
            r_addr     <= '0;
            r_data     <= '0;
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
            r_ar_valid <= 1'b0;
            r_b_ready  <= 1'b0;
            r_r_ready  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= FETCH;
                        r_idx   <= '0;
                        r_poll  <= '0;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                FETCH: begin
                    r_addr <= w_cmd.addr;
                    r_data <= w_cmd.data;
                    case (w_cmd.op)
                        OP_WRITE: begin
                            r_state    <= WR_REQ;
                            r_aw_valid <= 1'b1;
                            r_w_valid  <= 1'b1;
                        end
                        OP_POLL: begin
                            r_state    <= RD_REQ;
                            r_ar_valid <= 1'b1;
                        end
                        OP_END: begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                        default: begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    endcase
                end
                // AW and W retire independently; leave once neither is outstanding.
                WR_REQ: begin
                    if (axi_master_port.aw_ready) r_aw_valid <= 1'b0;
                    if (axi_master_port.w_ready)  r_w_valid  <= 1'b0;
                    if (!w_aw_pending && !w_w_pending) begin
                        r_state   <= WR_RESP;
                        r_b_ready <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (axi_master_port.b_valid) begin
                        r_b_ready <= 1'b0;
                        if (axi_master_port.b_resp != c_RESP_OKAY || w_last_idx) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= FETCH;
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                end
                RD_REQ: begin
                    if (axi_master_port.ar_ready) begin
                        r_ar_valid <= 1'b0;
                        r_r_ready  <= 1'b1;
                        r_state    <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (axi_master_port.r_valid) begin
                        r_r_ready <= 1'b0;
                        if (axi_master_port.r_resp != c_RESP_OKAY) begin
                            r_state <= ERR;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                        end else if (w_rd_word == r_data) begin
                            r_poll <= '0;
                            if (w_last_idx) begin
                                r_state <= ERR;
                                r_error <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state <= FETCH;
                                r_idx   <= r_idx + 1'b1;
                            end
                        end else begin
                            r_poll <= w_poll_next;
                            if (w_poll_next == c_POLL_MAX) begin
                                r_state <= ERR;
                                r_error <= 1'b1;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state    <= RD_REQ;
                                r_ar_valid <= 1'b1;
                            end
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                ERR:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cmd_idx_o = r_idx;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign error_o   = r_error;

    // Data bus is fixed at 64 bits; the 32-bit word is replicated on both halves.
    assign axi_master_port.aw_id     = {AXI_ID_WIDTH{1'b0}};
    assign axi_master_port.aw_addr   = AXI_ADDR_WIDTH'(r_addr);
    assign axi_master_port.aw_len    = 8'd0;
    assign axi_master_port.aw_size   = c_SIZE_4B;
    assign axi_master_port.aw_burst  = c_BURST_INCR;
    assign axi_master_port.aw_lock   = 1'b0;
    assign axi_master_port.aw_cache  = 4'd0;
    assign axi_master_port.aw_prot   = 3'd0;
    assign axi_master_port.aw_qos    = 4'd0;
    assign axi_master_port.aw_region = 4'd0;
    assign axi_master_port.aw_user   = {AXI_USER_WIDTH{1'b0}};
    assign axi_master_port.aw_valid  = r_aw_valid;

    assign axi_master_port.w_data    = AXI_DATA_WIDTH'({r_data, r_data});
    assign axi_master_port.w_strb    = lane_strb(r_addr[2]);
    assign axi_master_port.w_last    = 1'b1;
    assign axi_master_port.w_user    = {AXI_USER_WIDTH{1'b0}};
    assign axi_master_port.w_valid   = r_w_valid;

    assign axi_master_port.b_ready   = r_b_ready;

    assign axi_master_port.ar_id     = {AXI_ID_WIDTH{1'b0}};
    assign axi_master_port.ar_addr   = AXI_ADDR_WIDTH'(r_addr);
    assign axi_master_port.ar_len    = 8'd0;
    assign axi_master_port.ar_size   = c_SIZE_4B;
    assign axi_master_port.ar_burst  = c_BURST_INCR;
    assign axi_master_port.ar_lock   = 1'b0;
    assign axi_master_port.ar_cache  = 4'd0;
    assign axi_master_port.ar_prot   = 3'd0;
    assign axi_master_port.ar_qos    = 4'd0;
    assign axi_master_port.ar_region = 4'd0;
    assign axi_master_port.ar_user   = {AXI_USER_WIDTH{1'b0}};
    assign axi_master_port.ar_valid  = r_ar_valid;

    assign axi_master_port.r_ready   = r_r_ready;

    assign w_unused = ^{axi_master_port.b_id, axi_master_port.b_user,
                        axi_master_port.r_id, axi_master_port.r_last,
                        axi_master_port.r_user};

endmodule
`default_nettype wire

// File: tb/tb_cgra_cfg_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_cgra_cfg_sequencer                                        |
// | Description : Directed bench with a latency-configurable AXI slave.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_cgra_cfg_sequencer;
    import cgra_cfg_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  w_cmd_idx;
    logic [65:0] w_cmd;
    logic        w_busy;
    logic        w_done;
    logic        w_error;
    logic [65:0] tbl [16];

    assign w_cmd = tbl[w_cmd_idx];

    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64),
              .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(64)) axi ();

    cgra_cfg_sequencer #(
        .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4),
        .AXI_USER_WIDTH(64), .IDX_WIDTH(4), .POLL_TIMEOUT(4)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .cmd_idx_o(w_cmd_idx),
        .cmd_i(w_cmd), .busy_o(w_busy), .done_o(w_done), .error_o(w_error),
        .axi_master_port(axi)
    );

    always #5 clk = ~clk;

    // Slave configuration, written only by the test sequence
    int          cfg_aw_delay = 0;
    int          cfg_w_delay  = 0;
    logic [1:0]  cfg_bresp    = 2'b00;
    logic [63:0] rd_words [3];
    int          rd_base      = 0;

    // Slave state and transaction log, written only by the slave process
    int          cyc = 0, n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_done = 0;
    int          aw_t = 0, w_t = 0, aw_open = 0, w_open = 0, ar_open = 0;
    int          aw_wait = 0, w_wait = 0, k = 0;
    logic        p_aw = 0, p_w = 0, p_b = 0, p_ar = 0, p_r = 0;
    logic [63:0] c_aw_addr, c_w_data, last_aw_addr = '0, last_wdata = '0;
    logic [7:0]  c_w_strb, last_strb = '0;

    // Slave runs on the falling edge; a handshake seen here is taken at the next rise.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            axi.aw_ready = 0; axi.w_ready = 0; axi.ar_ready = 0;
            axi.b_valid = 0; axi.b_resp = 0; axi.b_id = 0; axi.b_user = 0;
            axi.r_valid = 0; axi.r_resp = 0; axi.r_id = 0; axi.r_user = 0;
            axi.r_last = 1; axi.r_data = 0;
            p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
            aw_open = 0; w_open = 0; ar_open = 0; aw_wait = 0; w_wait = 0;
        end else begin
            if (p_aw) begin n_aw++; aw_t = cyc; last_aw_addr = c_aw_addr; aw_open++; end
            if (p_w)  begin n_w++; w_t = cyc; last_wdata = c_w_data; last_strb = c_w_strb; w_open++; end
            if (p_b)  begin n_b++; axi.b_valid = 0; end
            if (p_ar) begin n_ar++; ar_open++; end
            if (p_r)  axi.r_valid = 0;
            if (w_done) n_done++;
            if (!axi.b_valid && aw_open > 0 && w_open > 0) begin
                axi.b_valid = 1; axi.b_resp = cfg_bresp; aw_open--; w_open--;
            end
            if (!axi.r_valid && ar_open > 0) begin
                k = n_ar - rd_base - 1;
                if (k > 2) k = 2;
                if (k < 0) k = 0;
                axi.r_valid = 1; axi.r_data = rd_words[k]; ar_open--;
            end
            if (axi.aw_valid) begin axi.aw_ready = (aw_wait >= cfg_aw_delay); aw_wait++; end
            else begin axi.aw_ready = 0; aw_wait = 0; end
            if (axi.w_valid) begin axi.w_ready = (w_wait >= cfg_w_delay); w_wait++; end
            else begin axi.w_ready = 0; w_wait = 0; end
            axi.ar_ready = axi.ar_valid;
            p_aw = axi.aw_valid && axi.aw_ready; c_aw_addr = axi.aw_addr;
            p_w  = axi.w_valid && axi.w_ready;   c_w_data = axi.w_data; c_w_strb = axi.w_strb;
            p_b  = axi.b_valid && axi.b_ready;
            p_ar = axi.ar_valid && axi.ar_ready;
            p_r  = axi.r_valid && axi.r_ready;
        end
    end

    typedef struct {
        string       name;
        logic [65:0] cmd [3];
        int          w_delay;
        logic [1:0]  bresp;
        logic [63:0] rd [3];
        int          exp_wr, exp_ar, exp_done;
        logic        exp_err;
        int          exp_idx;
        logic [63:0] exp_addr;
        logic [7:0]  exp_strb;
        logic [63:0] exp_wdata;
        int          exp_gap;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [65:0] mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
        return {op, a, d};
    endfunction

    function automatic vec_t mkv(input string n, input logic [65:0] c0, c1, c2,
                                 input int wd, input logic [1:0] br,
                                 input logic [63:0] r0, r1, r2,
                                 input int ewr, ear, edone, input logic eerr, input int eidx,
                                 input logic [63:0] eaddr, input logic [7:0] estrb,
                                 input logic [63:0] ewd, input int egap);
        vec_t v;
        v.name = n; v.cmd[0] = c0; v.cmd[1] = c1; v.cmd[2] = c2;
        v.w_delay = wd; v.bresp = br; v.rd[0] = r0; v.rd[1] = r1; v.rd[2] = r2;
        v.exp_wr = ewr; v.exp_ar = ear; v.exp_done = edone; v.exp_err = eerr;
        v.exp_idx = eidx; v.exp_addr = eaddr; v.exp_strb = estrb;
        v.exp_wdata = ewd; v.exp_gap = egap;
        return v;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (w_busy && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_finish"}, {63'd0, w_busy}, 64'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic run_vec(input vec_t v);
        int s_aw, s_w, s_b, s_ar, s_done;
        for (int i = 0; i < 16; i++) tbl[i] = mk(OP_END, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin tbl[i] = v.cmd[i]; rd_words[i] = v.rd[i]; end
        cfg_w_delay = v.w_delay;
        cfg_bresp   = v.bresp;
        rd_base     = n_ar;
        s_aw = n_aw; s_w = n_w; s_b = n_b; s_ar = n_ar; s_done = n_done;
        pulse_start();
        wait_idle(v.name);
        chk({v.name, "_aw_cnt"}, 64'(n_aw - s_aw), 64'(v.exp_wr));
        chk({v.name, "_w_cnt"},  64'(n_w - s_w),   64'(v.exp_wr));
        chk({v.name, "_b_cnt"},  64'(n_b - s_b),   64'(v.exp_wr));
        chk({v.name, "_ar_cnt"}, 64'(n_ar - s_ar), 64'(v.exp_ar));
        chk({v.name, "_done"},   64'(n_done - s_done), 64'(v.exp_done));
        chk({v.name, "_error"},  {63'd0, w_error}, {63'd0, v.exp_err});
        chk({v.name, "_idx"},    {60'd0, w_cmd_idx}, 64'(v.exp_idx));
        if (v.exp_wr > 0) begin
            chk({v.name, "_aw_addr"}, last_aw_addr, v.exp_addr);
            chk({v.name, "_w_strb"},  {56'd0, last_strb}, {56'd0, v.exp_strb});
            chk({v.name, "_w_data"},  last_wdata, v.exp_wdata);
            chk({v.name, "_w_gap"},   64'(w_t - aw_t), 64'(v.exp_gap));
        end
    endtask

    vec_t        vecs [7];
    logic [65:0] e_cmd;

    initial begin
        int n;
        int s_aw, s_done;
        rst = 1'b1;
        start = 1'b0;
        e_cmd = mk(OP_END, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) tbl[i] = e_cmd;
        for (int i = 0; i < 3; i++) rd_words[i] = '0;

        vecs[0] = mkv("wr_basic", mk(OP_WRITE, 32'h5000_0010, 32'h9000_0004), e_cmd, e_cmd,
                      0, 2'b00, 64'h0, 64'h0, 64'h0,
                      1, 0, 1, 1'b0, 1, 64'h5000_0010, 8'h0F, 64'h9000_0004_9000_0004, 0);
        vecs[1] = mkv("wr_wdelay", mk(OP_WRITE, 32'h5000_0024, 32'h1234_5678), e_cmd, e_cmd,
                      3, 2'b00, 64'h0, 64'h0, 64'h0,
                      1, 0, 1, 1'b0, 1, 64'h5000_0024, 8'hF0, 64'h1234_5678_1234_5678, 3);
        vecs[2] = mkv("poll_3rd", mk(OP_POLL, 32'h5000_0030, 32'h1),
                      mk(OP_WRITE, 32'h5000_0008, 32'hA), e_cmd,
                      0, 2'b00, 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001,
                      1, 3, 1, 1'b0, 2, 64'h5000_0008, 8'h0F, 64'h0000_000A_0000_000A, 0);
        vecs[3] = mkv("poll_timeout", mk(OP_POLL, 32'h5000_0034, 32'hDEAD_BEEF), e_cmd, e_cmd,
                      0, 2'b00, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_DEAD_BEEF,
                      0, 4, 0, 1'b1, 0, 64'h0, 8'h0, 64'h0, 0);
        vecs[4] = mkv("wr_slverr", mk(OP_WRITE, 32'h5000_0040, 32'h5), e_cmd, e_cmd,
                      0, 2'b10, 64'h0, 64'h0, 64'h0,
                      1, 0, 0, 1'b1, 0, 64'h5000_0040, 8'h0F, 64'h0000_0005_0000_0005, 0);
        vecs[5] = mkv("poll_hi", mk(OP_POLL, 32'h5000_0034, 32'h0000_CAFE), e_cmd, e_cmd,
                      0, 2'b00, 64'h0000_CAFE_0000_0000, 64'h0000_CAFE_0000_0000, 64'h0000_CAFE_0000_0000,
                      0, 1, 1, 1'b0, 1, 64'h0, 8'h0, 64'h0, 0);
        vecs[6] = mkv("illegal_op", mk(OP_ILLEGAL, 32'h5000_0000, 32'h0), e_cmd, e_cmd,
                      0, 2'b00, 64'h0, 64'h0, 64'h0,
                      0, 0, 0, 1'b1, 0, 64'h0, 8'h0, 64'h0, 0);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_busy",  {63'd0, w_busy},  64'd0);
        chk("rst_done",  {63'd0, w_done},  64'd0);
        chk("rst_error", {63'd0, w_error}, 64'd0);
        chk("rst_idx",   {60'd0, w_cmd_idx}, 64'd0);
        chk("rst_valids", {59'd0, axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}, 64'd0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Sixteen writes with no END: must error at the last index without wrapping
        for (int i = 0; i < 16; i++) tbl[i] = mk(OP_WRITE, 32'h5000_0000 + 32'(i * 8), 32'(i));
        cfg_bresp = 2'b00;
        s_aw = n_aw; s_done = n_done;
        pulse_start();
        wait_idle("overflow");
        chk("overflow_aw_cnt", 64'(n_aw - s_aw), 64'd16);
        chk("overflow_error",  {63'd0, w_error}, 64'd1);
        chk("overflow_done",   64'(n_done - s_done), 64'd0);
        chk("overflow_idx",    {60'd0, w_cmd_idx}, 64'd15);

        // A new start clears the sticky error as soon as it is accepted
        for (int i = 0; i < 16; i++) tbl[i] = e_cmd;
        tbl[0] = mk(OP_WRITE, 32'h5000_0010, 32'h9000_0004);
        s_done = n_done;
        pulse_start();
        chk("restart_error_clr", {63'd0, w_error}, 64'd0);
        chk("restart_busy",      {63'd0, w_busy},  64'd1);
        wait_idle("restart");
        chk("restart_done", 64'(n_done - s_done), 64'd1);

        // Asynchronous reset while both write channels are stalled
        cfg_aw_delay = 50;
        cfg_w_delay  = 50;
        pulse_start();
        n = 0;
        while (!axi.aw_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("midrst_aw_up", {62'd0, axi.aw_valid, axi.w_valid}, 64'd3);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("midrst_valids", {61'd0, axi.aw_valid, axi.w_valid, axi.b_ready}, 64'd0);
        chk("midrst_outs",   {57'd0, w_busy, w_done, w_error, w_cmd_idx}, 64'd0);
        cfg_aw_delay = 0;
        cfg_w_delay  = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_vec(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cgra_cfg_sequencer.md
CGRA_CFG_SEQUENCER -- requirements
Module: cgra_cfg_sequencer

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default 64, AXI address width.
REQ-002 Parameter AXI_DATA_WIDTH, default 64, AXI data width; only 64 is supported.
REQ-003 Parameter AXI_ID_WIDTH, default 4, ID width; all transactions use ID 0.
REQ-004 Parameter AXI_USER_WIDTH, default 64, user width; user fields are driven to 0.
REQ-005 Parameter IDX_WIDTH, default 4, command index width; the table holds up to 2^IDX_WIDTH entries.
REQ-006 Parameter POLL_TIMEOUT, default 1024, maximum number of poll reads per POLL command.
REQ-007 Port clk_i, input, 1, the single clock.
REQ-008 Port rst_i, input, 1, asynchronous active-high reset.
REQ-009 Port start_i, input, 1, one-cycle pulse that starts the sequence; it is sampled only in IDLE.
REQ-010 Port cmd_idx_o, output, IDX_WIDTH, index of the current command-table entry.
REQ-011 Port cmd_i, input, 66, combinational table entry {op[1:0], addr[31:0], data[31:0]}, valid in the same cycle as cmd_idx_o.
REQ-012 Port busy_o, output, 1, high from start until the DONE or ERR state.
REQ-013 Port done_o, output, 1, one-cycle pulse when an END command completes.
REQ-014 Port error_o, output, 1, sticky error flag, cleared by the next accepted start_i.
REQ-015 Port axi_master_port, AXI_BUS Master modport, parametrised as above; AW, W, B, AR and R channels are used.

Function
REQ-016 Opcodes shall be: WRITE=2'b00, POLL=2'b01, END=2'b10; 2'b11 shall be treated as illegal.
REQ-017 The FSM states shall be IDLE, FETCH, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE and ERR.
REQ-018 IDLE->FETCH on start_i, with cmd_idx_o and the poll counter set to 0 and error_o cleared.
REQ-019 FETCH shall decode cmd_i and latch addr/data:
- WRITE->WR_REQ
- POLL->RD_REQ
- END->DONE
- illegal->ERR
REQ-020 WR_REQ shall assert aw_valid and w_valid together in the first WR_REQ cycle (one cycle after FETCH).
- Each valid deasserts independently after its own handshake.
- The FSM moves to WR_RESP once both handshakes have completed, in either order or in the same cycle.
REQ-021 Every write shall be a single beat:
- aw_addr = {32'b0, addr}, aw_size = 3'b010, aw_len = 0, aw_burst = INCR, w_last = 1.
- w_data = {data, data}.
- w_strb = 8'hF0 if addr[2] = 1, else 8'h0F.
REQ-022 WR_RESP shall hold b_ready high.
- On a b handshake with b_resp = OKAY: FETCH with cmd_idx_o+1.
- On any other b_resp: ERR.
REQ-023 RD_REQ shall assert ar_valid (ar_size = 3'b010, ar_len = 0) until ar_ready, then move to RD_RESP.
REQ-024 RD_RESP shall hold r_ready high. The selected word is r_data[63:32] if addr[2] = 1, else r_data[31:0]. On an r handshake:
- r_resp not OKAY: ERR.
- Selected word equals data: FETCH with cmd_idx_o+1 and the poll counter cleared.
- Otherwise: increment the poll counter; if it reaches POLL_TIMEOUT go to ERR, else return to RD_REQ.
REQ-025 DONE shall pulse done_o for one cycle and return to IDLE.
REQ-026 ERR shall set error_o and return to IDLE in the next cycle; done_o shall not pulse.
REQ-027 If cmd_idx_o increments past 2^IDX_WIDTH-1 without an END command, the FSM shall go to ERR with no wrap-around.
REQ-028 start_i shall be ignored in every state except IDLE.
REQ-029 Valid signals shall not be withdrawn before their handshake, and address/data shall stay stable while valid is high.

Reset
REQ-030 Asynchronous rst_i assertion shall force IDLE, all valids low, all readies low, cmd_idx_o=0, poll counter=0, busy_o=0, done_o=0, error_o=0.
REQ-031 Reset mid-transaction shall abandon the transaction; no handshake recovery is required.

Structure
REQ-032 Opcode enum, the command struct (66-bit packed) and the state enum shall live in cgra_cfg_pkg.
REQ-033 The block shall be a single module with no sub-modules; the poll counter shall be $clog2(POLL_TIMEOUT+1) bits.

Verification
REQ-034 Table {WRITE 0x5000_0010 0x9000_0004; END}, slave always ready with OKAY -> one AW at 0x5000_0010, w_strb=0x0F, w_data=0x9000_0004_9000_0004, then done_o pulses once.
REQ-035 WRITE to 0x5000_0024 with w_ready delayed 3 cycles after aw_ready -> aw_valid drops first, w_strb=0xF0, exactly one B is accepted.
REQ-036 POLL 0x5000_0030 expecting 0x1, with the slave returning 0, 0, then 1 -> exactly 3 AR transactions, then the next command is fetched.
REQ-037 POLL that never matches, with POLL_TIMEOUT=4 -> exactly 4 reads, then error_o=1 and busy_o=0.
REQ-038 WRITE answered with b_resp=SLVERR -> ERR state and error_o=1; a later start_i clears error_o.
REQ-039 rst_i asserted while in WR_REQ -> aw_valid and w_valid drop immediately, all outputs return to their reset values.
